// File: rtl/analyzer_pkg.sv
// Shared analyzer definitions: default frame width, serializer state encoding
// and a counter-width helper used by the serial-link blocks.
package analyzer_pkg;

    localparam int FRAME_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of a down-counter that must hold values 0..n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_frame_serializer_if.sv
// Word-in / bit-out bundle of the frame serializer: the source side drives
// the handshake and observes the serial line and framing pulses.
interface piso_frame_serializer_if
    import analyzer_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             data_out;
    logic             bit_strobe;
    logic             busy;
    logic             frame_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, data_out, bit_strobe, busy, frame_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, data_out, bit_strobe, busy, frame_done
    );
endinterface

// File: rtl/bit_period_divider.sv
// Reloadable down-counter marking bit-period boundaries; tc is high while the
// count is zero. Shared by the transmit and receive sides of the serial link.
module bit_period_divider
    import analyzer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic tc
);
    localparam int             CW     = cnt_width(DIV);
    localparam logic [CW-1:0]  RELOAD = CW'(DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every always_comb output gets its default first, so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (dec) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: state flops use <= so every register samples its _d value from the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/piso_frame_serializer.sv
// MSB-first parallel-in serial-out transmitter: accepts a word on a valid/ready
// handshake and shifts it out at DIV clocks per bit, back-to-back if offered.
module piso_frame_serializer
    import analyzer_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH,
    parameter int DIV   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    piso_frame_serializer_if.slave   bus
);
    localparam int BW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             strobe_q, strobe_d;

    logic div_tc;
    logic in_shift;
    logic last_cycle;
    logic shift_now;
    logic ready;
    logic accept;

    assign in_shift   = (state_q == SHIFT);
    assign last_cycle = in_shift && div_tc && (bitcnt_q == '0);
    assign shift_now  = in_shift && div_tc && (bitcnt_q != '0);
    assign ready      = (state_q == IDLE) || last_cycle;
    assign accept     = bus.in_valid && ready;

    bit_period_divider #(
        .DIV (DIV)
    ) u_divider (
        .clk   (clk),
        .reset (reset),
        .load  (accept || shift_now),
        .dec   (in_shift),
        .tc    (div_tc)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        strobe_d = accept || shift_now;
        // A final-cycle accept takes priority so the next frame starts with no gap bit.
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = bus.in_data;
            bitcnt_d = BW'(WIDTH - 1);
        end else if (shift_now) begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q - BW'(1);
        end else if (last_cycle) begin
            state_d  = IDLE;
            shreg_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shift register is a small datapath register, not a memory, so it is cleared with the rest.
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            strobe_q <= strobe_d;
        end
    end

    // Gating by state lets reset force the line low without waiting for an edge.
    assign bus.in_ready   = ready;
    assign bus.data_out   = in_shift && shreg_q[WIDTH-1];
    assign bus.bit_strobe = strobe_q;
    assign bus.busy       = in_shift;
    assign bus.frame_done = last_cycle;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: a DIV=1 and a DIV=4 instance checked every
// cycle against a frame-position model, plus directed literal scenarios.
module tb_piso_frame_serializer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int ST = 3;
    localparam int BZ = 2;
    localparam int FD = 1;
    localparam int RY = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       vld[2];
    logic [7:0] dat[2];
    logic       do_w[2], st_w[2], bz_w[2], fd_w[2], rdy_w[2];

    piso_frame_serializer_if #(.WIDTH(W)) if0 ();
    piso_frame_serializer_if #(.WIDTH(W)) if1 ();

    assign if0.in_valid = vld[0];
    assign if0.in_data  = dat[0];
    assign if1.in_valid = vld[1];
    assign if1.in_data  = dat[1];
    assign do_w[0] = if0.data_out;   assign do_w[1] = if1.data_out;
    assign st_w[0] = if0.bit_strobe; assign st_w[1] = if1.bit_strobe;
    assign bz_w[0] = if0.busy;       assign bz_w[1] = if1.busy;
    assign fd_w[0] = if0.frame_done; assign fd_w[1] = if1.frame_done;
    assign rdy_w[0] = if0.in_ready;  assign rdy_w[1] = if1.in_ready;

    piso_frame_serializer #(.WIDTH(W), .DIV(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    piso_frame_serializer #(.WIDTH(W), .DIV(4)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // SIPO receivers shifting on bit_strobe, as the downstream logic does.
    logic [7:0] rx[2];
    always @(posedge clk) begin
        if (st_w[0]) rx[0] <= {rx[0][6:0], do_w[0]};
        if (st_w[1]) rx[1] <= {rx[1][6:0], do_w[1]};
    end

    // Model: a frame is a word plus a cycle index 0..W*DIV-1 into its transmission.
    bit         m_busy[2];
    int         m_cyc[2];
    logic [7:0] m_word[2];
    logic [7:0] m_done_word[2];
    int         m_done_cnt[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0;
                m_cyc[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int  len;
                bit  last;
                bit  acc;
                len  = W * div_of(i);
                last = m_busy[i] && (m_cyc[i] == len - 1);
                acc  = vld[i] && (!m_busy[i] || last);
                if (last) begin
                    m_done_word[i] = m_word[i];
                    m_done_cnt[i]  = m_done_cnt[i] + 1;
                end
                if (acc) begin
                    m_busy[i] = 1'b1;
                    m_word[i] = dat[i];
                    m_cyc[i]  = 0;
                end else if (last) begin
                    m_busy[i] = 1'b0;
                    m_cyc[i]  = 0;
                end else if (m_busy[i]) begin
                    m_cyc[i] = m_cyc[i] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        int seen[2];
        seen[0] = 0;
        seen[1] = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin
                    int   div;
                    logic e_d, e_st, e_fd;
                    div  = div_of(i);
                    e_d  = m_busy[i] ? m_word[i][7 - m_cyc[i] / div] : 1'b0;
                    e_st = m_busy[i] && (m_cyc[i] % div == 0);
                    e_fd = m_busy[i] && (m_cyc[i] == W * div - 1);
                    check($sformatf("dut%0d data_out", i), do_w[i], e_d);
                    check($sformatf("dut%0d bit_strobe", i), st_w[i], e_st);
                    check($sformatf("dut%0d busy", i), bz_w[i], m_busy[i]);
                    check($sformatf("dut%0d frame_done", i), fd_w[i], e_fd);
                    check($sformatf("dut%0d in_ready", i), rdy_w[i], !m_busy[i] || e_fd);
                    if (m_done_cnt[i] != seen[i]) begin
                        check($sformatf("dut%0d receiver word", i), rx[i], m_done_word[i]);
                        seen[i] = m_done_cnt[i];
                    end
                end
            end
        end
    end

    // Samples per offset after the accept edge: {data, strobe, busy, done, ready}.
    logic [4:0] s[0:70];
    logic [7:0] srx[0:70];

    function automatic logic [7:0] bits_at(input int base, input int div);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = s[base + k * div][D];
        return r;
    endfunction

    function automatic int cnt(input int pos, input int lo, input int hi);
        int n;
        n = 0;
        for (int k = lo; k <= hi; k++) n += int'(s[k][pos]);
        return n;
    endfunction

    task automatic wait_idle(input int i);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!m_busy[i]) return;
        end
        check("wait_idle timeout", 1, 0);
    endtask

    task automatic capture(input int i, input logic [7:0] w1, input bit two,
                           input logic [7:0] w2, input int from, input int ncap);
        bit pend, done2;
        pend  = 1'b0;
        done2 = 1'b0;
        wait_idle(i);
        @(posedge clk); #1;
        vld[i] = 1'b1;
        dat[i] = w1;
        @(posedge clk); #1;
        vld[i] = two && (from == 0);
        dat[i] = (two && from == 0) ? w2 : 8'($urandom);
        for (int off = 1; off <= ncap; off++) begin
            @(negedge clk);
            s[off]   = {do_w[i], st_w[i], bz_w[i], fd_w[i], rdy_w[i]};
            srx[off] = rx[i];
            if (pend) begin
                vld[i] = 1'b0;
                pend   = 1'b0;
            end else if (two && !done2 && off >= from) begin
                vld[i] = 1'b1;
                dat[i] = w2;
                if (s[off][RY]) begin
                    pend  = 1'b1;
                    done2 = 1'b1;
                end
            end else if (!vld[i]) begin
                dat[i] = 8'($urandom);
            end
        end
        vld[i] = 1'b0;
    endtask

    task automatic rand_drive(input int i, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            vld[i] = ($urandom_range(0, 3) != 0);
            dat[i] = 8'($urandom);
        end
        vld[i] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vld[0] = 1'b0; vld[1] = 1'b0;
        dat[0] = '0;   dat[1] = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset data_out", do_w[i], 0);
            check("reset bit_strobe", st_w[i], 0);
            check("reset busy", bz_w[i], 0);
            check("reset frame_done", fd_w[i], 0);
            check("reset in_ready", rdy_w[i], 1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 0xA5 at one clock per bit.
        capture(0, 8'hA5, 1'b0, 8'h00, 0, 10);
        check("a5 bits", bits_at(1, 1), 8'hA5);
        check("a5 strobes", cnt(ST, 1, 8), 8);
        check("a5 strobe after", s[9][ST], 0);
        check("a5 frame_done t+8", s[8][FD], 1);
        check("a5 frame_done count", cnt(FD, 1, 10), 1);
        check("a5 idle data t+9", s[9][D], 0);
        check("a5 idle busy t+9", s[9][BZ], 0);

        // Loopback into the SIPO receiver.
        capture(0, 8'h3C, 1'b0, 8'h00, 0, 10);
        check("loopback 3c", srx[9], 8'h3C);

        // 0x81 at four clocks per bit.
        capture(1, 8'h81, 1'b0, 8'h00, 0, 34);
        check("81 bits", bits_at(1, 4), 8'h81);
        check("81 strobes", cnt(ST, 1, 33), 8);
        check("81 strobe t+1", s[1][ST], 1);
        check("81 strobe t+2", s[2][ST], 0);
        check("81 strobe t+29", s[29][ST], 1);
        check("81 frame_done t+32", s[32][FD], 1);
        check("81 frame_done count", cnt(FD, 1, 34), 1);
        check("81 busy t+33", s[33][BZ], 0);

        // Back-to-back 0xFF then 0x00 with in_valid held.
        capture(0, 8'hFF, 1'b1, 8'h00, 0, 18);
        check("b2b first", bits_at(1, 1), 8'hFF);
        check("b2b second", bits_at(9, 1), 8'h00);
        check("b2b accept at done", {s[8][FD], s[8][RY]}, 2'b11);
        check("b2b busy span", cnt(BZ, 1, 16), 16);
        check("b2b strobe t+9", s[9][ST], 1);
        check("b2b busy t+17", s[17][BZ], 0);

        // Backpressure: 0x55 offered mid-frame.
        capture(0, 8'hC3, 1'b1, 8'h55, 3, 18);
        check("bp ready held off", cnt(RY, 3, 7), 0);
        check("bp in flight", bits_at(1, 1), 8'hC3);
        check("bp ready at done", s[8][RY], 1);
        check("bp second", bits_at(9, 1), 8'h55);
        check("bp busy t+17", s[17][BZ], 0);
        capture(1, 8'hC3, 1'b1, 8'h55, 5, 66);
        check("bp4 in flight", bits_at(1, 4), 8'hC3);
        check("bp4 done t+32", s[32][FD], 1);
        check("bp4 second", bits_at(33, 4), 8'h55);
        check("bp4 busy t+65", s[65][BZ], 0);

        // Asynchronous reset in bit 3 of 0xF0 (DIV=4: bit 3 spans t+13..t+16).
        wait_idle(1);
        @(posedge clk); #1;
        vld[1] = 1'b1;
        dat[1] = 8'hF0;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        repeat (13) @(negedge clk);
        check("pre-reset data", do_w[1], 1);
        check("pre-reset strobe", st_w[1], 1);
        check("pre-reset busy", bz_w[1], 1);
        #2 reset = 1'b1;
        #1;
        check("async data_out", do_w[1], 0);
        check("async bit_strobe", st_w[1], 0);
        check("async busy", bz_w[1], 0);
        check("async frame_done", fd_w[1], 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post-reset ready 1", rdy_w[1], 1);
        check("post-reset ready 0", rdy_w[0], 1);
        capture(1, 8'h0F, 1'b0, 8'h00, 0, 34);
        check("after reset 0f", bits_at(1, 4), 8'h0F);
        check("after reset done", s[32][FD], 1);
        capture(0, 8'h0F, 1'b0, 8'h00, 0, 10);
        check("after reset 0f div1", bits_at(1, 1), 8'h0F);

        // Random traffic on both instances, checked by the model every cycle.
        fork
            rand_drive(0, 600);
            rand_drive(1, 600);
        join
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
